// File: rtl/color_blender_pkg.sv
// rtl/color_blender_pkg.sv - shared channel positions and blend factor encodings
// Purpose: register/descriptor defines shared by the blend stage and its
//          configuration path.
// Contents: COLOR_*_POS channel slots (R in the MSBs), blend_factor_e codes.
package color_blender_pkg;

  localparam int NUM_CH      = 4;

  // Channel slot index within a pixel word; slot k occupies bits [k*SPW +: SPW].
  localparam int COLOR_R_POS = 3;
  localparam int COLOR_G_POS = 2;
  localparam int COLOR_B_POS = 1;
  localparam int COLOR_A_POS = 0;

  typedef enum logic [3:0] {
    BF_ZERO                = 4'd0,
    BF_ONE                 = 4'd1,
    BF_SRC_COLOR           = 4'd2,
    BF_ONE_MINUS_SRC_COLOR = 4'd3,
    BF_DST_COLOR           = 4'd4,
    BF_ONE_MINUS_DST_COLOR = 4'd5,
    BF_SRC_ALPHA           = 4'd6,
    BF_ONE_MINUS_SRC_ALPHA = 4'd7,
    BF_DST_ALPHA           = 4'd8,
    BF_ONE_MINUS_DST_ALPHA = 4'd9,
    BF_SRC_ALPHA_SATURATE  = 4'd10
  } blend_factor_e;

endpackage

// File: rtl/color_mul_norm.sv
// rtl/color_mul_norm.sv - one channel of registered normalised colour * factor
// Purpose: o_r = (p + (p >> SPW) + 2^(SPW-1)) >> SPW with p = i_c * i_f,
//          so a full-scale factor returns the colour unchanged and zero gives zero.
// Ports:
//   aclk, reset  clock, synchronous active-high reset
//   ce           advance enable; 0 holds the result register
//   i_c, i_f     colour channel and blend factor (SPW bits each)
//   o_r          registered normalised product (SPW bits)
module color_mul_norm #(
  parameter int SPW = 8
) (
  input  logic           aclk,
  input  logic           reset,
  input  logic           ce,
  input  logic [SPW-1:0] i_c,
  input  logic [SPW-1:0] i_f,
  output logic [SPW-1:0] o_r
);

  logic [2*SPW-1:0] w_p;
  logic [2*SPW:0]   w_sum;
  logic             w_unused;
  logic [SPW-1:0]   r_r;

  assign w_p = i_c * i_f;

  // Adding p >> SPW approximates division by (2^SPW - 1) instead of 2^SPW;
  // the worst case (255*255) stays below 2^(2*SPW), so the top bit is always 0.
  assign w_sum = {1'b0, w_p}
               + {{(SPW + 1){1'b0}}, w_p[2*SPW-1:SPW]}
               + {{(SPW + 1){1'b0}}, 1'b1, {(SPW - 1){1'b0}}};

  assign w_unused = ^{w_sum[2*SPW], w_sum[SPW-1:0]};

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_r <= '0;
    end else if (ce) begin
      r_r <= w_sum[2*SPW-1:SPW];
    end
  end

  assign o_r = r_r;

endmodule

// File: rtl/color_blender.sv
// rtl/color_blender.sv - three-stage framebuffer blend: out = src*Fs + dst*Fd
// Purpose: blends the fogged fragment colour with the framebuffer colour per RGBA
//          channel using GL-style factors; passes src through when disabled.
// Ports:
//   aclk, reset        clock, synchronous active-high reset
//   ce                 pipeline advance; 0 holds every stage
//   s_valid/s_tag      input fragment valid and opaque tag
//   s_src_color        fogged fragment colour (RGBA, R in MSBs)
//   s_dst_color        framebuffer colour at the fragment position
//   confEnable         1 = blend, 0 = pass src
//   confSrcFactor/Dst  blend factor codes (blend_factor_e)
//   m_valid/m_tag      output valid and tag, 3 ce cycles after input
//   m_color            blended colour
module color_blender
  import color_blender_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH = 8,
  parameter int TAG_WIDTH       = 16
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         s_valid,
  input  logic [TAG_WIDTH-1:0]         s_tag,
  input  logic [4*SUB_PIXEL_WIDTH-1:0] s_src_color,
  input  logic [4*SUB_PIXEL_WIDTH-1:0] s_dst_color,
  input  logic                         confEnable,
  input  logic [3:0]                   confSrcFactor,
  input  logic [3:0]                   confDstFactor,
  output logic                         m_valid,
  output logic [TAG_WIDTH-1:0]         m_tag,
  output logic [4*SUB_PIXEL_WIDTH-1:0] m_color
);

  localparam int             SPW = SUB_PIXEL_WIDTH;
  localparam logic [SPW-1:0] MAX = '1;

  // Factor for one channel. Saturate is only meaningful as a source factor;
  // undefined codes and dst-side saturate resolve to zero.
  function automatic logic [SPW-1:0] f_resolve(
    input logic [3:0]     i_code,
    input logic           i_is_dst,
    input logic           i_is_alpha,
    input logic [SPW-1:0] i_cs,
    input logic [SPW-1:0] i_as,
    input logic [SPW-1:0] i_cd,
    input logic [SPW-1:0] i_ad
  );
    logic [SPW-1:0] v_sat;
    logic [SPW-1:0] v_f;
    v_sat = (i_as < (MAX - i_ad)) ? i_as : (MAX - i_ad);
    case (blend_factor_e'(i_code))
      BF_ZERO:                v_f = '0;
      BF_ONE:                 v_f = MAX;
      BF_SRC_COLOR:           v_f = i_cs;
      BF_ONE_MINUS_SRC_COLOR: v_f = MAX - i_cs;
      BF_DST_COLOR:           v_f = i_cd;
      BF_ONE_MINUS_DST_COLOR: v_f = MAX - i_cd;
      BF_SRC_ALPHA:           v_f = i_as;
      BF_ONE_MINUS_SRC_ALPHA: v_f = MAX - i_as;
      BF_DST_ALPHA:           v_f = i_ad;
      BF_ONE_MINUS_DST_ALPHA: v_f = MAX - i_ad;
      BF_SRC_ALPHA_SATURATE:  v_f = i_is_dst ? '0 : (i_is_alpha ? MAX : v_sat);
      default:                v_f = '0;
    endcase
    return v_f;
  endfunction

  logic [SPW-1:0]             w_as;
  logic [SPW-1:0]             w_ad;
  logic [NUM_CH-1:0][SPW-1:0] w_fs;
  logic [NUM_CH-1:0][SPW-1:0] w_fd;
  logic [NUM_CH-1:0][SPW-1:0] w_rs;
  logic [NUM_CH-1:0][SPW-1:0] w_rd;
  logic [NUM_CH-1:0][SPW:0]   w_sum;
  logic [4*SPW-1:0]           w_blend;

  // Stage 1: fragment plus its own latched config and resolved factors.
  logic                       r1_valid;
  logic [TAG_WIDTH-1:0]       r1_tag;
  logic                       r1_en;
  logic [4*SPW-1:0]           r1_src;
  logic [4*SPW-1:0]           r1_dst;
  logic [NUM_CH-1:0][SPW-1:0] r1_fs;
  logic [NUM_CH-1:0][SPW-1:0] r1_fd;

  // Stage 2: products live inside color_mul_norm; sidebands ride alongside.
  logic                       r2_valid;
  logic [TAG_WIDTH-1:0]       r2_tag;
  logic                       r2_en;
  logic [4*SPW-1:0]           r2_src;

  assign w_as = s_src_color[COLOR_A_POS*SPW +: SPW];
  assign w_ad = s_dst_color[COLOR_A_POS*SPW +: SPW];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign w_fs[ch] = f_resolve(confSrcFactor, 1'b0, (ch == COLOR_A_POS),
                                s_src_color[ch*SPW +: SPW], w_as,
                                s_dst_color[ch*SPW +: SPW], w_ad);
    assign w_fd[ch] = f_resolve(confDstFactor, 1'b1, (ch == COLOR_A_POS),
                                s_src_color[ch*SPW +: SPW], w_as,
                                s_dst_color[ch*SPW +: SPW], w_ad);

    color_mul_norm #(.SPW(SPW)) u_mul_src (
      .aclk  (aclk),
      .reset (reset),
      .ce    (ce),
      .i_c   (r1_src[ch*SPW +: SPW]),
      .i_f   (r1_fs[ch]),
      .o_r   (w_rs[ch])
    );

    color_mul_norm #(.SPW(SPW)) u_mul_dst (
      .aclk  (aclk),
      .reset (reset),
      .ce    (ce),
      .i_c   (r1_dst[ch*SPW +: SPW]),
      .i_f   (r1_fd[ch]),
      .o_r   (w_rd[ch])
    );

    // Stage 3 saturating add: carry out means the sum exceeded full scale.
    assign w_sum[ch] = {1'b0, w_rs[ch]} + {1'b0, w_rd[ch]};
    assign w_blend[ch*SPW +: SPW] = w_sum[ch][SPW] ? MAX : w_sum[ch][SPW-1:0];
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r1_tag   <= '0;
      r1_en    <= 1'b0;
      r1_src   <= '0;
      r1_dst   <= '0;
      r1_fs    <= '0;
      r1_fd    <= '0;
    end else if (ce) begin
      r1_valid <= s_valid;
      r1_tag   <= s_tag;
      r1_en    <= confEnable;
      r1_src   <= s_src_color;
      r1_dst   <= s_dst_color;
      r1_fs    <= w_fs;
      r1_fd    <= w_fd;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r2_valid <= 1'b0;
      r2_tag   <= '0;
      r2_en    <= 1'b0;
      r2_src   <= '0;
    end else if (ce) begin
      r2_valid <= r1_valid;
      r2_tag   <= r1_tag;
      r2_en    <= r1_en;
      r2_src   <= r1_src;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_tag   <= '0;
      m_color <= '0;
    end else if (ce) begin
      m_valid <= r2_valid;
      m_tag   <= r2_tag;
      m_color <= r2_en ? w_blend : r2_src;
    end
  end

endmodule

// File: tb/tb_color_blender.sv
// tb/tb_color_blender.sv - randomized bench for color_blender against a behavioural model
module tb_color_blender;

  localparam int SPW = 8;
  localparam int TW  = 16;

  logic          aclk = 1'b0;
  logic          reset;
  logic          ce;
  logic          s_valid;
  logic [TW-1:0] s_tag;
  logic [31:0]   s_src_color;
  logic [31:0]   s_dst_color;
  logic          confEnable;
  logic [3:0]    confSrcFactor;
  logic [3:0]    confDstFactor;
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [31:0]   m_color;

  always #5 aclk = ~aclk;

  color_blender #(.SUB_PIXEL_WIDTH(SPW), .TAG_WIDTH(TW)) dut (
    .aclk          (aclk),
    .reset         (reset),
    .ce            (ce),
    .s_valid       (s_valid),
    .s_tag         (s_tag),
    .s_src_color   (s_src_color),
    .s_dst_color   (s_dst_color),
    .confEnable    (confEnable),
    .confSrcFactor (confSrcFactor),
    .confDstFactor (confDstFactor),
    .m_valid       (m_valid),
    .m_tag         (m_tag),
    .m_color       (m_color)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: GL blend on 0..255 integers, factor 255 meaning 1.0.
  function automatic int fac(int code, bit is_dst, bit is_alpha, int cs, int as, int cd, int ad);
    case (code)
      0:  return 0;
      1:  return 255;
      2:  return cs;
      3:  return 255 - cs;
      4:  return cd;
      5:  return 255 - cd;
      6:  return as;
      7:  return 255 - as;
      8:  return ad;
      9:  return 255 - ad;
      10: begin
        if (is_dst) return 0;
        if (is_alpha) return 255;
        return (as < 255 - ad) ? as : 255 - ad;
      end
      default: return 0;
    endcase
  endfunction

  function automatic int norm(int c, int f);
    int p;
    p = c * f;
    return (p + p / 256 + 128) / 256;
  endfunction

  function automatic logic [31:0] blend(logic [31:0] src, logic [31:0] dst, bit en, int fs, int fd);
    logic [31:0] res;
    int as, ad, cs, cd, s;
    if (!en) return src;
    res = 0;
    as  = int'(src & 32'hFF);
    ad  = int'(dst & 32'hFF);
    for (int ch = 0; ch < 4; ch++) begin
      cs = int'((src >> (8 * (3 - ch))) & 32'hFF);
      cd = int'((dst >> (8 * (3 - ch))) & 32'hFF);
      s  = norm(cs, fac(fs, 1'b0, ch == 3, cs, as, cd, ad))
         + norm(cd, fac(fd, 1'b1, ch == 3, cs, as, cd, ad));
      if (s > 255) s = 255;
      res = res | (32'(s) << (8 * (3 - ch)));
    end
    return res;
  endfunction

  typedef struct {
    int          due;
    logic [15:0] tag;
    logic [31:0] color;
  } exp_t;

  exp_t        q[$];
  int          ecount = 0;
  bit          lv     = 1'b0;
  logic [15:0] ltag   = '0;
  logic [31:0] lcol   = '0;
  logic [15:0] next_tag = 16'd100;

  // One clock: drive inputs, advance, then compare outputs 1ns after the edge.
  task automatic step(input bit c, input bit v, input logic [15:0] tg,
                      input logic [31:0] src, input logic [31:0] dst,
                      input bit en, input int fs, input int fd,
                      input bit use_exp, input logic [31:0] expc);
    exp_t e;
    ce            = c;
    s_valid       = v;
    s_tag         = tg;
    s_src_color   = src;
    s_dst_color   = dst;
    confEnable    = en;
    confSrcFactor = 4'(fs);
    confDstFactor = 4'(fd);
    @(posedge aclk);
    #1;
    if (c) begin
      ecount++;
      if (v) begin
        e.due   = ecount + 2;
        e.tag   = tg;
        e.color = use_exp ? expc : blend(src, dst, en, fs, fd);
        q.push_back(e);
      end
      if (q.size() > 0 && q[0].due == ecount) begin
        e = q.pop_front();
        check("out_valid", 64'(m_valid), 64'd1);
        check("out_tag",   64'(m_tag),   64'(e.tag));
        check("out_color", 64'(m_color), 64'(e.color));
        lv   = 1'b1;
        ltag = e.tag;
        lcol = e.color;
      end else begin
        check("idle_valid", 64'(m_valid), 64'd0);
        lv = 1'b0;
      end
    end else begin
      check("hold_valid", 64'(m_valid), 64'(lv));
      if (lv) begin
        check("hold_tag",   64'(m_tag),   64'(ltag));
        check("hold_color", 64'(m_color), 64'(lcol));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0, 32'd0);
  endtask

  task automatic rand_frag(input bit c, input bit v);
    step(c, v, next_tag, $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
         int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, 32'd0);
    if (c && v) next_tag++;
  endtask

  initial begin
    int accepted;
    bit c;
    reset         = 1'b1;
    ce            = 1'b0;
    s_valid       = 1'b0;
    s_tag         = '0;
    s_src_color   = '0;
    s_dst_color   = '0;
    confEnable    = 1'b0;
    confSrcFactor = '0;
    confDstFactor = '0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_tag",   64'(m_tag),   64'd0);
    check("rst_color", 64'(m_color), 64'd0);
    reset = 1'b0;

    // Directed cases with hand-computed results.
    step(1, 1, 16'd1, 32'h11223344, 32'hAABBCCDD, 0, 0,  0, 1, 32'h11223344);
    step(1, 1, 16'd2, 32'h80402010, 32'hFFFFFFFF, 1, 1,  0, 1, 32'h80402010);
    step(1, 1, 16'd3, 32'hF0F0F0F0, 32'h20202020, 1, 1,  1, 1, 32'hFFFFFFFF);
    step(1, 1, 16'd4, 32'hFF000080, 32'h0000FF80, 1, 6,  7, 1, 32'h80007F80);
    step(1, 1, 16'd5, 32'hFFFFFF80, 32'h000000C0, 1, 10, 1, 1, 32'h3F3F3FFF);
    idle(4);

    // Ten tagged fragments with ce toggling and per-fragment config changes.
    accepted = 0;
    while (accepted < 10) begin
      c = ($urandom_range(0, 2) != 0);
      rand_frag(c, 1'b1);
      if (c) accepted++;
    end
    idle(4);

    // Longer random mix of stalls and bubbles.
    for (int i = 0; i < 300; i++) begin
      rand_frag(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    idle(4);

    // Reset with three fragments in flight and ce held low.
    for (int i = 0; i < 3; i++) rand_frag(1'b1, 1'b1);
    reset   = 1'b1;
    ce      = 1'b0;
    s_valid = 1'b0;
    @(posedge aclk);
    #1;
    check("midrst_valid", 64'(m_valid), 64'd0);
    check("midrst_color", 64'(m_color), 64'd0);
    check("midrst_tag",   64'(m_tag),   64'd0);
    reset = 1'b0;
    q.delete();
    lv   = 1'b0;
    ltag = '0;
    lcol = '0;
    idle(6);

    for (int i = 0; i < 5; i++) rand_frag(1'b1, 1'b1);
    idle(4);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
